// File: rtl/ecgai_pkg.sv
// ecgai_pkg: shared frame-geometry defaults, packer FSM state type and packing helpers.
package ecgai_pkg;
  localparam int PACK_W_DEF = 16;
  localparam int POS_N_DEF = 64;
  localparam int CH_N_DEF = 32;
  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_e;
  function automatic int wpc(input int pos_n, input int pack_w);
    return (pos_n + pack_w - 1) / pack_w;
  endfunction
  function automatic int popcount(input logic [31:0] v);
    popcount = 0;
    for (int i = 0; i < 32; i++) popcount += int'(v[i]);
  endfunction
endpackage

// File: rtl/binary_act_packer_if.sv
// binary_act_packer_if: bit-stream input and packed-word write bus; PACKER_POPCOUNT_EN adds wr_popcnt.
interface binary_act_packer_if #(parameter int PACK_W = 16, parameter int ADDR_W = 10);
  logic bin_valid, bin_data, bin_ready, wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PACK_W-1:0] wr_data;
`ifdef PACKER_POPCOUNT_EN
  logic [$clog2(PACK_W+1)-1:0] wr_popcnt;
  modport master(output bin_valid, bin_data, wr_ready, input bin_ready, wr_valid, wr_addr, wr_data, wr_popcnt);
  modport slave(input bin_valid, bin_data, wr_ready, output bin_ready, wr_valid, wr_addr, wr_data, wr_popcnt);
`else
  modport master(output bin_valid, bin_data, wr_ready, input bin_ready, wr_valid, wr_addr, wr_data);
  modport slave(input bin_valid, bin_data, wr_ready, output bin_ready, wr_valid, wr_addr, wr_data);
`endif
endinterface

// File: rtl/binary_act_packer_bit_shift_packer.sv
// bit_shift_packer: LSB-first bit accumulator with bit counter and word-close detection.
module bit_shift_packer #(parameter int PACK_W = 16) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              ch_end,
  output logic              close,
  output logic [PACK_W-1:0] word
);
  localparam int BW = $clog2(PACK_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(PACK_W - 1);
  logic [PACK_W-1:0] sr_q, sr_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  // bits above bit_cnt are always zero, so a channel-end close pads with 0
  always_comb begin
    word = sr_q;
    word[bit_cnt_q] = bit_in;
    close = shift && (bit_cnt_q == BIT_LAST || ch_end);
    sr_d = (clr || close) ? '0 : shift ? word : sr_q;
    bit_cnt_d = (clr || close) ? '0 : shift ? bit_cnt_q + 1'b1 : bit_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/binary_act_packer.sv
// binary_act_packer: packs a binarized activation stream into addressed SRAM words; PACKER_POPCOUNT_EN adds wr_popcnt.
module binary_act_packer import ecgai_pkg::*; #(
  parameter int PACK_W = PACK_W_DEF,
  parameter int POS_N = POS_N_DEF,
  parameter int CH_N = CH_N_DEF,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic frame_done,
  binary_act_packer_if.slave bus
);
  localparam int PW = POS_N > 1 ? $clog2(POS_N) : 1;
  localparam int CW = CH_N > 1 ? $clog2(CH_N) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(POS_N - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CH_N - 1);
  state_e state_q, state_d;
  logic [PW-1:0] pos_cnt_q, pos_cnt_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d, wr_addr_q, wr_addr_d;
  logic [PACK_W-1:0] wr_data_q, wr_data_d, word;
  logic wr_valid_q, wr_valid_d;
  logic go, accept, bin_ready, xfer, ch_end, last, close;
  bit_shift_packer #(.PACK_W(PACK_W)) u_pack (
    .clk(clk), .rst_n(rst_n), .clr(go), .shift(xfer), .bit_in(bus.bin_data),
    .ch_end(ch_end), .close(close), .word(word)
  );
  // a pending unaccepted word blocks input; acceptance in this cycle frees it
  always_comb begin
    go = state_q == IDLE && start;
    accept = wr_valid_q && bus.wr_ready;
    bin_ready = state_q == PACK && !(wr_valid_q && !bus.wr_ready);
    xfer = bus.bin_valid && bin_ready;
    ch_end = pos_cnt_q == POS_LAST;
    last = xfer && ch_end && ch_cnt_q == CH_LAST;
    state_d = go ? PACK
            : last ? DRAIN
            : (state_q == DRAIN && accept) ? DONE
            : state_q == DONE ? IDLE : state_q;
    pos_cnt_d = go ? '0 : xfer ? (ch_end ? '0 : pos_cnt_q + 1'b1) : pos_cnt_q;
    ch_cnt_d = go ? '0 : (xfer && ch_end) ? (ch_cnt_q == CH_LAST ? '0 : ch_cnt_q + 1'b1) : ch_cnt_q;
    word_cnt_d = go ? '0 : close ? word_cnt_q + 1'b1 : word_cnt_q;
    wr_valid_d = close || (wr_valid_q && !accept);
    wr_data_d = close ? word : wr_data_q;
    wr_addr_d = close ? word_cnt_q : wr_addr_q;
    busy = state_q == PACK || state_q == DRAIN;
    frame_done = state_q == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_cnt_q <= '0;
      ch_cnt_q <= '0;
      word_cnt_q <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      pos_cnt_q <= pos_cnt_d;
      ch_cnt_q <= ch_cnt_d;
      word_cnt_q <= word_cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end
  assign bus.bin_ready = bin_ready;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_addr = wr_addr_q;
`ifdef PACKER_POPCOUNT_EN
  localparam int CNTW = $clog2(PACK_W + 1);
  logic [CNTW-1:0] popcnt_q, popcnt_d;
  always_comb popcnt_d = close ? CNTW'(popcount(32'(word))) : popcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) popcnt_q <= '0;
    else popcnt_q <= popcnt_d;
  end
  assign bus.wr_popcnt = popcnt_q;
`endif
endmodule

// File: tb/tb_binary_act_packer.sv
// tb_binary_act_packer: scoreboard bench driving two packer geometries (POS_N 20 and 32) with a packing model.
module tb_binary_act_packer;
  import ecgai_pkg::*;
  typedef struct {
    logic [9:0] addr;
    logic [15:0] data;
    bit last;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, bin_valid = 0, bin_data = 0, wr_ready = 1, sel = 0;
  logic busy_a, busy_b, done_a, done_b;
  logic m_valid, m_bin_ready, m_busy, m_done;
  logic [9:0] m_addr;
  logic [15:0] m_data;
  int errors = 0, checks = 0, rdy_mode = 0, held = 0;
  exp_t q[$];
  binary_act_packer_if #(.PACK_W(16), .ADDR_W(10)) ifa();
  binary_act_packer_if #(.PACK_W(16), .ADDR_W(10)) ifb();
  always #5 clk = ~clk;
  assign ifa.bin_valid = bin_valid;
  assign ifa.bin_data = bin_data;
  assign ifa.wr_ready = wr_ready;
  assign ifb.bin_valid = bin_valid;
  assign ifb.bin_data = bin_data;
  assign ifb.wr_ready = wr_ready;
  assign m_valid = sel ? ifb.wr_valid : ifa.wr_valid;
  assign m_bin_ready = sel ? ifb.bin_ready : ifa.bin_ready;
  assign m_addr = sel ? ifb.wr_addr : ifa.wr_addr;
  assign m_data = sel ? ifb.wr_data : ifa.wr_data;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
`ifdef PACKER_POPCOUNT_EN
  logic [4:0] m_pop;
  assign m_pop = sel ? ifb.wr_popcnt : ifa.wr_popcnt;
`endif
  binary_act_packer #(.PACK_W(16), .POS_N(20), .CH_N(2), .ADDR_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .busy(busy_a), .frame_done(done_a), .bus(ifa));
  binary_act_packer #(.PACK_W(16), .POS_N(32), .CH_N(2), .ADDR_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .busy(busy_b), .frame_done(done_b), .bus(ifb));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // mode 0: alternating 1,0 from bit 0; mode 1: all ones; mode 2: random bits and bin_valid gaps
  task automatic run_frame(input bit s, input int mode, input int nbits, input bit pulse);
    int pos_n = s ? 32 : 20;
    int ch_n = 2;
    int wpc_n = (pos_n + 15) / 16;
    int i, budget;
    bit bits[$];
    sel = s;
    for (int k = 0; k < pos_n * ch_n; k++)
      bits.push_back(mode == 0 ? (k % 2 == 0) : mode == 1 ? 1'b1 : 1'($urandom_range(0, 1)));
    for (int c = 0; c < ch_n; c++)
      for (int w = 0; w < wpc_n; w++) begin
        exp_t e;
        int lo, hi;
        lo = w * 16;
        hi = (lo + 16 < pos_n) ? lo + 16 : pos_n;
        e.data = '0;
        for (int p = lo; p < hi; p++) e.data[p - lo] = bits[c * pos_n + p];
        e.addr = 10'(c * wpc_n + w);
        e.last = (c == ch_n - 1) && (w == wpc_n - 1);
        if (c * pos_n + hi - 1 < nbits) q.push_back(e);
      end
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    #1 chk("busy_after_start", int'(m_busy), 1);
    i = 0;
    budget = 0;
    while (i < nbits && budget < 4000) begin
      @(negedge clk);
      start = pulse && i == 5;
      bin_valid = mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1;
      bin_data = bits[i];
      #1;
      if (bin_valid && m_bin_ready) i++;
      budget++;
    end
    chk("bits_accepted", i, nbits);
    @(negedge clk);
    bin_valid = 0;
    start = 0;
    if (nbits == pos_n * ch_n) begin
      budget = 0;
      while (!m_done && budget < 500) begin
        @(negedge clk);
        #1;
        budget++;
      end
      chk("frame_done_seen", int'(m_done), 1);
      if (pulse) start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      #1 chk("idle_busy", int'(m_busy), 0);
      chk("idle_no_word", int'(m_valid), 0);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rdy_mode == 2) wr_ready = $urandom_range(0, 2) != 0;
    else if (rdy_mode == 1 && m_valid && held < 10) begin
      wr_ready = 0;
      held++;
    end else wr_ready = 1;
  end

  initial begin
    bit stall = 0, due = 0;
    logic [9:0] pa;
    logic [15:0] pd;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 0;
        due = 0;
      end else begin
        if (due || m_done) begin
          checks++;
          if (m_done !== due) begin
            errors++;
            $display("FAIL frame_done got=%0b want=%0b", m_done, due);
          end
        end
        due = 0;
        if (stall && m_valid) begin
          checks++;
          if (m_addr !== pa || m_data !== pd) begin
            errors++;
            $display("FAIL hold_stable got=%0h/%0h want=%0h/%0h", m_addr, m_data, pa, pd);
          end
        end
        if (m_valid && !wr_ready) begin
          checks++;
          if (m_bin_ready !== 1'b0) begin
            errors++;
            $display("FAIL bin_ready_stall got=%0b want=0", m_bin_ready);
          end
        end
        stall = m_valid && !wr_ready;
        pa = m_addr;
        pd = m_data;
        if (m_valid && wr_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got addr=%0h data=%0h want none", m_addr, m_data);
          end else begin
            e = q.pop_front();
            if (m_addr !== e.addr || m_data !== e.data) begin
              errors++;
              $display("FAIL word got addr=%0h data=%0h want addr=%0h data=%0h", m_addr, m_data, e.addr, e.data);
            end
`ifdef PACKER_POPCOUNT_EN
            checks++;
            if (m_pop !== 5'($countones(e.data))) begin
              errors++;
              $display("FAIL popcnt got=%0d want=%0d", m_pop, $countones(e.data));
            end
`endif
            due = e.last;
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 chk("rst_valid", int'(m_valid), 0);
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_bin_ready", int'(m_bin_ready), 0);
    @(negedge clk);
    rst_n = 1;
    run_frame(0, 0, 40, 0);
    held = 0;
    rdy_mode = 1;
    run_frame(0, 0, 40, 0);
    rdy_mode = 0;
    run_frame(0, 1, 40, 1);
    run_frame(1, 1, 64, 0);
    run_frame(1, 0, 23, 0);
    repeat (3) @(negedge clk);
    chk("drained_before_reset", q.size(), 0);
    rst_n = 0;
    #1 chk("rst_mid_valid", int'(m_valid), 0);
    chk("rst_mid_addr", int'(m_addr), 0);
    chk("rst_mid_data", int'(m_data), 0);
    chk("rst_mid_busy", int'(m_busy), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    #1 chk("no_word_after_reset", int'(m_valid), 0);
    run_frame(1, 1, 64, 0);
    rdy_mode = 2;
    run_frame(0, 2, 40, 0);
    run_frame(1, 2, 64, 0);
    run_frame(0, 2, 40, 0);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
